// File: rtl/counter_pkg.sv
// Shared constants and helpers for the up/down modulo counter.
package counter_pkg;

    // Direction encoding for up_dn
    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Default parameterisation matches the old fixed 4-bit counter
    localparam int DEF_WIDTH    = 4;
    localparam int DEF_MODULUS  = 16;
    localparam int DEF_PRESCALE = 1;

    // Bits needed to hold values 0..value-1 (0 for value <= 1)
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides the enable stream: tick fires on every PRESCALE-th enabled clock.
module tick_prescaler
    import counter_pkg::*;
#(
    parameter int PRESCALE = DEF_PRESCALE
) (
    input  logic clock,
    input  logic Reset,
    input  logic en,
    input  logic sclr,
    output logic tick
);

    if (PRESCALE == 1) begin : g_bypass
        // No divider state at all: every enabled clock is a step
        logic unused_inputs;
        assign unused_inputs = ^{clock, Reset, sclr};
        assign tick          = en;
    end else begin : g_count
        localparam int              CntW = clog2(PRESCALE);
        localparam logic [CntW-1:0] Term = CntW'(PRESCALE - 1);

        logic [CntW-1:0] cnt_q, cnt_d;

        assign tick = en && (cnt_q == Term);

        // Next prescale count: clear wins, wrap on tick, hold partial count while en is low
        always_comb begin
            cnt_d = cnt_q;
            if (sclr) begin
                cnt_d = '0;
            end else if (tick) begin
                cnt_d = '0;
            end else if (en) begin
                cnt_d = cnt_q + CntW'(1);
            end
        end

        // Prescale count register
        always_ff @(posedge clock or posedge Reset) begin
            if (Reset) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end
    end

endmodule

// File: rtl/updown_mod_counter.sv
// Up/down modulo-MODULUS counter with clear, load, prescaled enable and status flags.
module updown_mod_counter
    import counter_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int MODULUS  = DEF_MODULUS,
    parameter int PRESCALE = DEF_PRESCALE
) (
    input  logic             clock,
    input  logic             Reset,
    input  logic             en,
    input  logic             up_dn,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] Q,
    output logic             tc,
    output logic             wrap,
    output logic             load_err
);

    if (MODULUS < 2 || longint'(MODULUS) > (longint'(1) << WIDTH) ||
        PRESCALE < 1 || PRESCALE > 256) begin : g_bad_params
        $error("updown_mod_counter: illegal WIDTH/MODULUS/PRESCALE combination");
    end

    localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MODULUS - 1);
    // One extra bit so MODULUS == 2^WIDTH is representable
    localparam logic [WIDTH:0]   ModExt = (WIDTH + 1)'(MODULUS);

    logic [WIDTH-1:0] q_q, q_d;
    logic             wrap_q, wrap_d;
    logic             load_err_q, load_err_d;
    logic             step;
    logic             load_ok;

    tick_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_tick_prescaler (
        .clock (clock),
        .Reset (Reset),
        .en    (en),
        .sclr  (clr | load),
        .tick  (step)
    );

    assign load_ok = ({1'b0, load_val} < ModExt);

    // Next count and flag pulses: clr > load > step > hold
    always_comb begin
        q_d        = q_q;
        wrap_d     = 1'b0;
        load_err_d = 1'b0;
        if (clr) begin
            q_d = '0;
        end else if (load) begin
            if (load_ok) begin
                q_d = load_val;
            end else begin
                q_d        = MaxVal;
                load_err_d = 1'b1;
            end
        end else if (step) begin
            if (up_dn == DIR_UP) begin
                if (q_q == MaxVal) begin
                    q_d    = '0;
                    wrap_d = 1'b1;
                end else begin
                    q_d = q_q + WIDTH'(1);
                end
            end else begin
                if (q_q == '0) begin
                    q_d    = MaxVal;
                    wrap_d = 1'b1;
                end else begin
                    q_d = q_q - WIDTH'(1);
                end
            end
        end
    end

    // Count and flag registers
    always_ff @(posedge clock or posedge Reset) begin
        if (Reset) begin
            q_q        <= '0;
            wrap_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            q_q        <= q_d;
            wrap_q     <= wrap_d;
            load_err_q <= load_err_d;
        end
    end

    // Terminal count depends only on the current value and direction
    always_comb begin
        tc = ((up_dn == DIR_UP) && (q_q == MaxVal)) || ((up_dn == DIR_DOWN) && (q_q == '0));
    end

    assign Q        = q_q;
    assign wrap     = wrap_q;
    assign load_err = load_err_q;

endmodule

// File: tb/tb_updown_mod_counter.sv
// Bench for updown_mod_counter: two instances (PRESCALE 1 and 3) share one stimulus stream.
module tb_updown_mod_counter;

    localparam int M = 10;

    logic       clock = 1'b0;
    logic       Reset = 1'b1;
    logic       en = 1'b0, up_dn = 1'b1, clr = 1'b0, load = 1'b0;
    logic [3:0] load_val = 4'd0;

    logic [3:0] qa, qb;
    logic       tca, tcb, wa, wb, ea, eb;

    updown_mod_counter #(.WIDTH(4), .MODULUS(M), .PRESCALE(1)) dut_a (
        .clock(clock), .Reset(Reset), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
        .load_val(load_val), .Q(qa), .tc(tca), .wrap(wa), .load_err(ea)
    );

    updown_mod_counter #(.WIDTH(4), .MODULUS(M), .PRESCALE(3)) dut_b (
        .clock(clock), .Reset(Reset), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
        .load_val(load_val), .Q(qb), .tc(tcb), .wrap(wb), .load_err(eb)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model state, index 0 = dut_a, 1 = dut_b
    int pre[2] = '{1, 3};
    int mq[2];
    int mpc[2];
    bit mw[2];
    bit me[2];

    typedef struct {
        bit         en;
        bit         up;
        bit         clr;
        bit         load;
        logic [3:0] lv;
        int         q;
        bit         tc;
        bit         wrap;
        bit         err;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            mq[d] = 0; mpc[d] = 0; mw[d] = 0; me[d] = 0;
        end
    endtask

    // One rising edge of the reference model, using the spec's rules directly
    task automatic model_edge();
        int nq;
        if (Reset) begin
            model_reset();
            return;
        end
        for (int d = 0; d < 2; d++) begin
            mw[d] = 0;
            me[d] = 0;
            if (clr) begin
                mq[d] = 0; mpc[d] = 0;
            end else if (load) begin
                if (int'(load_val) < M) mq[d] = int'(load_val);
                else begin
                    mq[d] = M - 1; me[d] = 1;
                end
                mpc[d] = 0;
            end else if (en) begin
                if (mpc[d] == pre[d] - 1) begin
                    mpc[d] = 0;
                    if (up_dn) begin
                        nq = (mq[d] + 1) % M;
                        mw[d] = (nq == 0);
                    end else begin
                        nq = (mq[d] + M - 1) % M;
                        mw[d] = (nq == M - 1);
                    end
                    mq[d] = nq;
                end else begin
                    mpc[d] = mpc[d] + 1;
                end
            end
        end
    endtask

    task automatic check_models(input string tag);
        bit mtc;
        for (int d = 0; d < 2; d++) begin
            mtc = (up_dn && mq[d] == M - 1) || (!up_dn && mq[d] == 0);
            chk($sformatf("%s.q%0d", tag, d), (d == 0) ? qa : qb, mq[d]);
            chk($sformatf("%s.tc%0d", tag, d), (d == 0) ? tca : tcb, mtc);
            chk($sformatf("%s.wrap%0d", tag, d), (d == 0) ? wa : wb, mw[d]);
            chk($sformatf("%s.lerr%0d", tag, d), (d == 0) ? ea : eb, me[d]);
        end
    endtask

    // Advance one clock; inputs are changed only at #1 after an edge
    task automatic tick();
        @(posedge clock);
        model_edge();
        #1;
    endtask

    task automatic set_in(input bit e, input bit u, input bit c, input bit l,
                          input logic [3:0] v);
        en = e; up_dn = u; clr = c; load = l; load_val = v;
    endtask

    initial begin
        model_reset();

        // Reset state while Reset is held
        tick();
        tick();
        chk("reset.q_a", qa, 0);
        chk("reset.q_b", qb, 0);
        chk("reset.wrap", wa, 0);
        chk("reset.lerr", ea, 0);
        Reset = 1'b0;

        // Count up 12 clocks
        for (int i = 1; i <= 12; i++) begin
            tbl.push_back('{1, 1, 0, 0, 4'd0, i % 10, (i % 10) == 9, (i % 10) == 0, 0});
        end
        // Load 2 then count down through the wrap
        tbl.push_back('{1, 0, 0, 1, 4'd2, 2, 0, 0, 0});
        tbl.push_back('{1, 0, 0, 0, 4'd0, 1, 0, 0, 0});
        tbl.push_back('{1, 0, 0, 0, 4'd0, 0, 1, 0, 0});
        tbl.push_back('{1, 0, 0, 0, 4'd0, 9, 0, 1, 0});
        tbl.push_back('{1, 0, 0, 0, 4'd0, 8, 0, 0, 0});
        // Out-of-range load saturates and pulses load_err for one cycle
        tbl.push_back('{0, 0, 0, 1, 4'd13, 9, 0, 0, 1});
        tbl.push_back('{0, 0, 0, 0, 4'd0, 9, 0, 0, 0});
        tbl.push_back('{0, 0, 0, 1, 4'd5, 5, 0, 0, 0});
        // clr beats load beats step
        tbl.push_back('{0, 1, 0, 1, 4'd7, 7, 0, 0, 0});
        tbl.push_back('{1, 1, 1, 1, 4'd3, 0, 0, 0, 0});
        tbl.push_back('{1, 1, 0, 1, 4'd4, 4, 0, 0, 0});

        foreach (tbl[i]) begin
            set_in(tbl[i].en, tbl[i].up, tbl[i].clr, tbl[i].load, tbl[i].lv);
            tick();
            chk($sformatf("vec%0d.q", i), qa, tbl[i].q);
            chk($sformatf("vec%0d.tc", i), tca, tbl[i].tc);
            chk($sformatf("vec%0d.wrap", i), wa, tbl[i].wrap);
            chk($sformatf("vec%0d.lerr", i), ea, tbl[i].err);
            check_models($sformatf("vec%0d", i));
        end

        // Prescale by 3 with a two-clock enable gap mid-prescale
        set_in(0, 1, 1, 0, 4'd0);
        tick();
        set_in(1, 1, 0, 0, 4'd0);
        tick();
        tick();
        chk("pre.before_step", qb, 0);
        tick();
        chk("pre.first_step", qb, 1);
        tick();
        en = 1'b0;
        tick();
        tick();
        chk("pre.hold_gap", qb, 1);
        en = 1'b1;
        tick();
        chk("pre.delayed", qb, 1);
        tick();
        chk("pre.second_step", qb, 2);
        check_models("pre");

        // Asynchronous reset between edges at Q=6
        set_in(0, 1, 0, 1, 4'd6);
        tick();
        chk("areset.pre_q", qa, 6);
        load = 1'b0;
        #3;
        Reset = 1'b1;
        model_reset();
        #1;
        chk("areset.q_a", qa, 0);
        chk("areset.q_b", qb, 0);
        tick();
        check_models("areset_hold");
        Reset = 1'b0;
        set_in(1, 1, 0, 0, 4'd0);
        tick();
        chk("areset.resume", qa, 1);
        check_models("areset_resume");

        // Randomised run against the model
        for (int i = 0; i < 400; i++) begin
            set_in($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                   $urandom_range(0, 15) == 0, $urandom_range(0, 9) == 0,
                   4'($urandom_range(0, 15)));
            if ($urandom_range(0, 99) == 0) begin
                #2;
                Reset = 1'b1;
                model_reset();
                #1;
                check_models($sformatf("rnd%0d_rst", i));
                Reset = 1'b0;
            end
            tick();
            check_models($sformatf("rnd%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
